// File: rtl/mem_xbar_n.sv
// N-region data-memory crossbar: decodes one upstream request against base/limit
// windows, forwards it to a variable-latency target, returns one response.
// Optional watchdog enabled by defining MEM_XBAR_TIMEOUT_EN.
module mem_xbar_n #(
    parameter int NREG = 2,
    parameter int AW = 30,
    parameter int DW = 32,
    parameter logic [NREG*AW-1:0] REGION_BASE = '0,
    parameter logic [NREG*AW-1:0] REGION_LIMIT = '0,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [AW-1:0]        i_addr,
    input  logic [DW-1:0]        i_data,
    input  logic                 i_wren,
    input  logic [DW/8-1:0]      i_mask,
    output logic                 o_rsp_valid,
    output logic [DW-1:0]        o_rsp_data,
    output logic                 o_rsp_err,
    output logic [NREG-1:0]      o_tgt_valid,
    output logic [AW-1:0]        o_tgt_addr,
    output logic [DW-1:0]        o_tgt_data,
    output logic                 o_tgt_wren,
    output logic [DW/8-1:0]      o_tgt_mask,
    input  logic [NREG-1:0]      i_tgt_ready,
    input  logic [NREG-1:0]      i_tgt_rvalid,
    input  logic [NREG*DW-1:0]   i_tgt_rdata
);
    localparam int MW = DW / 8;
    localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RDATA, RESP} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [NREG-1:0] tgt_valid_q, tgt_valid_d;
    logic [AW-1:0]   tgt_addr_q, tgt_addr_d;
    logic [DW-1:0]   tgt_data_q, tgt_data_d;
    logic            tgt_wren_q, tgt_wren_d;
    logic [MW-1:0]   tgt_mask_q, tgt_mask_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;

    logic            hit;
    logic [SW-1:0]   hit_sel;
    logic [AW-1:0]   hit_base;
    logic            timeout;

    // Scan from the top so the lowest-index matching region is the last one written.
    always_comb begin
        hit      = 1'b0;
        hit_sel  = '0;
        hit_base = '0;
        for (int k = NREG - 1; k >= 0; k--) begin
            if (i_addr >= REGION_BASE[k*AW +: AW] && i_addr < REGION_LIMIT[k*AW +: AW]) begin
                hit      = 1'b1;
                hit_sel  = SW'(k);
                hit_base = REGION_BASE[k*AW +: AW];
            end
        end
    end

`ifdef MEM_XBAR_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] cnt_q, cnt_d;

    // Zero in the first REQ cycle, so the limit is reached after TIMEOUT busy cycles.
    assign cnt_d   = (state_q == REQ || state_q == RDATA) ? cnt_q + 1'b1 : '0;
    assign timeout = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        tgt_valid_d = tgt_valid_q;
        tgt_addr_d  = tgt_addr_q;
        tgt_data_d  = tgt_data_q;
        tgt_wren_d  = tgt_wren_q;
        tgt_mask_d  = tgt_mask_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    if (hit) begin
                        sel_d       = hit_sel;
                        tgt_valid_d = NREG'(1) << hit_sel;
                        tgt_addr_d  = i_addr - hit_base;
                        tgt_data_d  = i_data;
                        tgt_wren_d  = i_wren;
                        tgt_mask_d  = i_mask;
                        state_d     = REQ;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            REQ: begin
                if (i_tgt_ready[sel_q]) begin
                    tgt_valid_d = '0;
                    if (tgt_wren_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b0;
                        state_d     = RESP;
                    end else begin
                        state_d = RDATA;
                    end
                end else if (timeout) begin
                    tgt_valid_d = '0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end
            end
            RDATA: begin
                if (i_tgt_rvalid[sel_q]) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = i_tgt_rdata[sel_q*DW +: DW];
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else if (timeout) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            tgt_valid_q <= '0;
            tgt_addr_q  <= '0;
            tgt_data_q  <= '0;
            tgt_wren_q  <= 1'b0;
            tgt_mask_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            tgt_valid_q <= tgt_valid_d;
            tgt_addr_q  <= tgt_addr_d;
            tgt_data_q  <= tgt_data_d;
            tgt_wren_q  <= tgt_wren_d;
            tgt_mask_q  <= tgt_mask_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign o_req_ready = (state_q == IDLE);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_tgt_valid = tgt_valid_q;
    assign o_tgt_addr  = tgt_addr_q;
    assign o_tgt_data  = tgt_data_q;
    assign o_tgt_wren  = tgt_wren_q;
    assign o_tgt_mask  = tgt_mask_q;

endmodule

// File: tb/tb_mem_xbar_n.sv
// Bench for mem_xbar_n: directed vector table, reset corner cases and random
// transactions checked against a cycle-count model of the crossbar protocol.
module tb_mem_xbar_n;
    localparam int NREG = 3;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int TO = 16;
    localparam logic [NREG*AW-1:0] RB = {30'h4008, 30'h4000, 30'h0};
    localparam logic [NREG*AW-1:0] RL = {30'h4100, 30'h4010, 30'h400};

    logic              clk, rst_n;
    logic              i_req_valid, o_req_ready;
    logic [AW-1:0]     i_addr;
    logic [DW-1:0]     i_data;
    logic              i_wren;
    logic [MW-1:0]     i_mask;
    logic              o_rsp_valid;
    logic [DW-1:0]     o_rsp_data;
    logic              o_rsp_err;
    logic [NREG-1:0]   o_tgt_valid;
    logic [AW-1:0]     o_tgt_addr;
    logic [DW-1:0]     o_tgt_data;
    logic              o_tgt_wren;
    logic [MW-1:0]     o_tgt_mask;
    logic [NREG-1:0]   i_tgt_ready, i_tgt_rvalid;
    logic [NREG*DW-1:0] i_tgt_rdata;

    mem_xbar_n #(.NREG(NREG), .AW(AW), .DW(DW), .REGION_BASE(RB),
                 .REGION_LIMIT(RL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_addr(i_addr), .i_data(i_data), .i_wren(i_wren), .i_mask(i_mask),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
        .o_tgt_valid(o_tgt_valid), .o_tgt_addr(o_tgt_addr), .o_tgt_data(o_tgt_data),
        .o_tgt_wren(o_tgt_wren), .o_tgt_mask(o_tgt_mask), .i_tgt_ready(i_tgt_ready),
        .i_tgt_rvalid(i_tgt_rvalid), .i_tgt_rdata(i_tgt_rdata));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [AW-1:0] mbase [NREG] = '{30'h0, 30'h4000, 30'h4008};
    logic [AW-1:0] mlim  [NREG] = '{30'h400, 30'h4010, 30'h4100};

    typedef struct {
        logic [AW-1:0] a;
        bit            w;
        logic [DW-1:0] d;
        logic [MW-1:0] m;
        int            dr;
        int            dv;
        logic [DW-1:0] rd;
        bit            hit;
        int            sel;
        logic [AW-1:0] rel;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // First region (lowest index) containing the address wins.
    function automatic void model_decode(input logic [AW-1:0] a, output bit hit,
                                         output int sel, output logic [AW-1:0] rel);
        hit = 1'b0; sel = 0; rel = '0;
        for (int k = 0; k < NREG; k++) begin
            if (!hit && a >= mbase[k] && a < mlim[k]) begin
                hit = 1'b1; sel = k; rel = a - mbase[k];
            end
        end
    endfunction

    task automatic rand_tgt();
        for (int k = 0; k < NREG; k++) begin
            i_tgt_ready[k]  = 1'($urandom);
            i_tgt_rvalid[k] = 1'($urandom);
            i_tgt_rdata[k*DW +: DW] = $urandom;
        end
    endtask

    // dr: cycles target waits before ready; dv: cycles between accept and rvalid.
    task automatic do_txn(input logic [AW-1:0] a, input bit w, input logic [DW-1:0] d,
                          input logic [MW-1:0] m, input int dr, input int dv,
                          input logic [DW-1:0] rd, input bit hit, input int sel,
                          input logic [AW-1:0] rel);
        int L, vend;
        bit to, eerr;
        logic [DW-1:0] edata;
        logic [NREG-1:0] etv;
        if (!hit) L = 1;
        else if (w) L = dr + 2;
        else L = dr + dv + 3;
        vend = hit ? dr + 1 : 0;
        to = 1'b0;
`ifdef MEM_XBAR_TIMEOUT_EN
        if (hit && L > TO + 1) begin
            to = 1'b1; L = TO + 1;
            if (vend > TO) vend = TO;
        end
`endif
        eerr  = !hit || to;
        edata = (hit && !w && !to) ? rd : '0;
        chk("req_ready_idle", 128'(o_req_ready), 128'(1'b1));
        i_req_valid = 1'b1; i_addr = a; i_wren = w; i_data = d; i_mask = m;
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0; i_addr = AW'($urandom); i_data = $urandom;
        i_wren = 1'($urandom); i_mask = MW'($urandom);
        for (int c = 1; c <= L + 1; c++) begin
            etv = (hit && c <= vend) ? (NREG'(1) << sel) : '0;
            chk("tgt_valid", 128'(o_tgt_valid), 128'(etv));
            chk("ready_rspvalid", 128'({o_req_ready, o_rsp_valid}), 128'({c == L + 1, c == L}));
            if (c == 1 && hit)
                chk("tgt_fields", 128'({o_tgt_addr, o_tgt_data, o_tgt_wren, o_tgt_mask}),
                    128'({rel, d, w, m}));
            if (c >= L)
                chk("rsp_data_err", 128'({o_rsp_data, o_rsp_err}), 128'({edata, eerr}));
            rand_tgt();
            if (hit) begin
                i_tgt_ready[sel]  = (c == dr + 1);
                i_tgt_rvalid[sel] = (c <= dr + 1) ? 1'($urandom) : (!w && c == dr + 2 + dv);
                if (!w && c == dr + 2 + dv) i_tgt_rdata[sel*DW +: DW] = rd;
            end
            if (c <= L) @(negedge clk);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, 128'({o_rsp_valid, o_rsp_data, o_rsp_err, o_tgt_valid, o_tgt_addr,
                      o_tgt_data, o_tgt_wren, o_tgt_mask}), 128'(0));
        chk({nm, "_ready"}, 128'(o_req_ready), 128'(1'b1));
    endtask

    vec_t tbl[10];

    initial begin
        logic [AW-1:0] a, r;
        bit h;
        int s;
        tbl[0] = '{30'h3FF,  1, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0,        1, 0, 30'h3FF};
        tbl[1] = '{30'h4004, 0, 32'h0,        4'hF, 3, 0, 32'h12345678, 1, 1, 30'h4};
        tbl[2] = '{30'h400,  0, 32'h0,        4'hF, 0, 0, 32'h0,        0, 0, 30'h0};
        tbl[3] = '{30'h90,   0, 32'h0,        4'hF, 0, 2, 32'hA5A50001, 1, 0, 30'h90};
        tbl[4] = '{30'h400C, 0, 32'h0,        4'h3, 1, 1, 32'h0BADF00D, 1, 1, 30'hC};
        tbl[5] = '{30'h4010, 1, 32'h01020304, 4'h5, 2, 0, 32'h0,        1, 2, 30'h8};
        tbl[6] = '{30'h40FF, 0, 32'h0,        4'hF, 0, 0, 32'hCAFEBABE, 1, 2, 30'hF7};
        tbl[7] = '{30'h4100, 1, 32'h11111111, 4'hF, 0, 0, 32'h0,        0, 0, 30'h0};
        tbl[8] = '{30'h3FFFFFFF, 0, 32'h0,    4'hF, 0, 0, 32'h0,        0, 0, 30'h0};
        tbl[9] = '{30'h0,    0, 32'h0,        4'h1, 0, 3, 32'h76543210, 1, 0, 30'h0};

        rst_n = 1'b0; i_req_valid = 1'b0; i_addr = '0; i_data = '0; i_wren = 1'b0;
        i_mask = '0; i_tgt_ready = '0; i_tgt_rvalid = '0; i_tgt_rdata = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            do_txn(tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].m, tbl[i].dr, tbl[i].dv,
                   tbl[i].rd, tbl[i].hit, tbl[i].sel, tbl[i].rel);

        // Reset while waiting for read data: no response afterwards.
        i_req_valid = 1'b1; i_addr = 30'h4004; i_wren = 1'b0; i_tgt_ready = '0; i_tgt_rvalid = '0;
        @(posedge clk); @(negedge clk);
        i_req_valid = 1'b0; i_tgt_ready = 3'b010;
        @(negedge clk);
        i_tgt_ready = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_all_zero("reset_in_rdata");
        @(negedge clk);
        rst_n = 1'b1;
        i_tgt_rvalid = 3'b111; i_tgt_rdata = {3{32'h55AA55AA}};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", 128'(o_rsp_valid), 128'(0));
        end
        i_tgt_rvalid = '0;
        do_txn(30'h4004, 0, 0, 4'hF, 0, 0, 32'h9ABCDEF0, 1, 1, 30'h4);

        // Reset while the request is presented: o_tgt_valid drops at once.
        i_req_valid = 1'b1; i_addr = 30'h10; i_wren = 1'b1; i_tgt_ready = '0;
        @(posedge clk); @(negedge clk);
        i_req_valid = 1'b0;
        chk("tgt_valid_before_reset", 128'(o_tgt_valid), 128'(3'b001));
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("tgt_valid_reset_drop", 128'(o_tgt_valid), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef MEM_XBAR_TIMEOUT_EN
        do_txn(30'h10, 1, 32'h77, 4'hF, 1000, 0, 0, 1, 0, 30'h10);
        do_txn(30'h4020, 0, 0, 4'hF, 2, 30, 32'h1234, 1, 2, 30'h18);
`endif

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: a = AW'($urandom_range(0, 32'h410));
                1: a = AW'($urandom_range(32'h3FF0, 32'h4110));
                2: a = AW'($urandom);
                default: a = AW'($urandom_range(32'h3F0, 32'h410));
            endcase
            model_decode(a, h, s, r);
            do_txn(a, 1'($urandom), $urandom, MW'($urandom), $urandom_range(0, 4),
                   $urandom_range(0, 4), $urandom, h, s, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
